l1_mem_arbiter: RTL

//  Shares the single line-wide physical-memory (L2) port between the icache and dcache miss ports of
//  the pipelined cpu_datapath. Serves one line transfer at a time, from grant to mem_resp.

---
 rtl/l1_mem_arbiter_pkg.sv | 28 ++
 rtl/l1_mem_arbiter_reg.sv | 32 +++
 rtl/l1_mem_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/l1_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : l1_mem_arbiter_pkg
// Brief  : Shared LC-3b types for the L1 miss-port / L2 arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package l1_mem_arbiter_pkg;

    localparam int LC3B_WORD_W     = 16;
    localparam int LC3B_DATBUS_W   = 128;
    localparam int LC3B_LINE_OFF_W = 4;

    typedef logic [LC3B_WORD_W-1:0]   lc3b_word;
    typedef logic [LC3B_DATBUS_W-1:0] lc3b_datbus;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } lc3b_arb_state;

    typedef enum logic {
        ARB_OP_RD = 1'b0,
        ARB_OP_WR = 1'b1
    } lc3b_arb_op;

endpackage
`default_nettype wire

// File: rtl/l1_mem_arbiter_reg.sv
`default_nettype none
// ============================================================================
// Module : l1_mem_arbiter_reg
// Brief  : Generic load-enabled register with asynchronous active-low clear.
// Rev    : 1.0  initial release
// ============================================================================
module l1_mem_arbiter_reg
    import l1_mem_arbiter_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/l1_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : l1_mem_arbiter
// Brief  : Arbitrates the icache and dcache miss ports onto one line-wide L2
//          port, one transfer at a time. Define ARB_ROUND_ROBIN_EN to replace
//          fixed dcache priority with alternating tie-break.
// Rev    : 1.0  initial release
// ============================================================================
module l1_mem_arbiter
    import l1_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = LC3B_WORD_W,
    parameter int LINE_W = LC3B_DATBUS_W,
    parameter int OFF_W  = LC3B_LINE_OFF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [LINE_W-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE    = ARB_IDLE;
    localparam logic [1:0] ST_SERVE_I = ARB_SERVE_I;
    localparam logic [1:0] ST_SERVE_D = ARB_SERVE_D;

    localparam int LATCH_W = LINE_W + ADDR_W + 2;
    localparam int RD_BIT  = LATCH_W - 1;
    localparam int WR_BIT  = LATCH_W - 2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_idle;
    logic               w_i_req;
    logic               w_d_req;
    logic               w_pick_d;
    logic               w_grant_i;
    logic               w_grant_d;
    logic               w_done;
    lc3b_arb_op         w_d_op;
    logic [ADDR_W-1:0]  w_i_addr_al;
    logic [ADDR_W-1:0]  w_d_addr_al;
    logic               w_latch_ld;
    logic [LATCH_W-1:0] w_latch_d;
    logic [LATCH_W-1:0] w_latch_q;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;
    assign w_done  = ((r_state == ST_SERVE_I) || (r_state == ST_SERVE_D)) && mem_resp;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = dcache held the bus for the most recent completed transfer
    logic r_last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d <= 1'b0;
        end else if (w_done) begin
            r_last_d <= (r_state == ST_SERVE_D);
        end
    end

    always_comb begin
        w_pick_d = w_d_req;
        if (w_d_req && w_i_req) begin
            w_pick_d = ~r_last_d;
        end
    end
`else
    // dcache wins ties: it belongs to the older instruction in the pipe
    assign w_pick_d = w_d_req;
`endif

    assign w_grant_d = w_idle & w_d_req & w_pick_d;
    assign w_grant_i = w_idle & w_i_req & ~w_pick_d;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = ST_SERVE_D;
                end else if (w_grant_i) begin
                    w_state_nxt = ST_SERVE_I;
                end
            end
            ST_SERVE_I,
            ST_SERVE_D: begin
                if (mem_resp) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An illegal read+write request resolves to a writeback
    assign w_d_op      = d_write ? ARB_OP_WR : ARB_OP_RD;
    assign w_i_addr_al = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_d_addr_al = {d_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Loaded on grant, cleared on completion so strobes fall the edge after mem_resp
    assign w_latch_ld = w_grant_d | w_grant_i | w_done;

    always_comb begin
        w_latch_d = '0;
        if (w_grant_d) begin
            w_latch_d = {w_d_op == ARB_OP_RD, w_d_op == ARB_OP_WR, w_d_addr_al, d_wdata};
        end else if (w_grant_i) begin
            w_latch_d = {1'b1, 1'b0, w_i_addr_al, {LINE_W{1'b0}}};
        end
    end

    l1_mem_arbiter_reg #(
        .WIDTH (LATCH_W)
    ) u_req_latch (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_latch_ld),
        .i_d    (w_latch_d),
        .o_q    (w_latch_q)
    );

    assign mem_read  = w_latch_q[RD_BIT];
    assign mem_write = w_latch_q[WR_BIT];
    assign mem_addr  = w_latch_q[LINE_W +: ADDR_W];
    assign mem_wdata = w_latch_q[LINE_W-1:0];

    assign i_resp  = (r_state == ST_SERVE_I) & mem_resp;
    assign d_resp  = (r_state == ST_SERVE_D) & mem_resp;
    assign i_rdata = i_resp ? mem_rdata : {LINE_W{1'b0}};
    assign d_rdata = d_resp ? mem_rdata : {LINE_W{1'b0}};

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(d_read && d_write));
        end
    end
`endif

endmodule
`default_nettype wire
